// File: rtl/led_page_scheduler_pkg.sv
// Shared state encoding, bank geometry and page slicing for the LED page scheduler.
package led_pkg;

    localparam int LEDW  = 10;
    localparam int DW    = 32;
    localparam int NPAGE = (DW + LEDW - 1) / LEDW;
    localparam int PAGEW = 2;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        SHOW,
        DONE
    } state_t;

    // Bits above the word's MSB read as zero on the last page.
    function automatic logic [LEDW-1:0] page_slice(input logic [DW-1:0]    word,
                                                   input logic [PAGEW-1:0] k);
        logic [NPAGE*LEDW-1:0] padded;
        padded = {{(NPAGE*LEDW-DW){1'b0}}, word};
        return padded[k*LEDW +: LEDW];
    endfunction

endpackage

// File: rtl/led_page_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rrPtr,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   winIdx,
    output logic            valid
);

    int scan;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value held (no latch).
        winner = '0;
        winIdx = '0;
        valid  = 1'b0;
        scan   = 0;
        // Scan farthest-to-nearest so the requester nearest rrPtr is written last and wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            scan = (int'(rrPtr) + i) % NREQ;
            if (req[PW'(scan)]) begin
                winner            = '0;
                winner[PW'(scan)] = 1'b1;
                winIdx            = PW'(scan);
                valid             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_page_scheduler.sv
// Time-shares the LED bank between requesters, showing each granted word as paged slices.
// Optional LED_PAGE_IDX_EN adds the pageIdx output.
module led_page_scheduler
    import led_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = led_pkg::DW,
    parameter int LEDW  = led_pkg::LEDW,
    parameter int DWELL = 50000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] reqData,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic [LEDW-1:0]  ledOut,
    output logic             done
`ifdef LED_PAGE_IDX_EN
    ,
    output logic [1:0]       pageIdx
`endif
);

    localparam int PW  = $clog2(NREQ);
    localparam int DCW = $clog2(DWELL + 1);
    localparam logic [DCW-1:0]   DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [PAGEW-1:0] PAGE_LAST  = PAGEW'(NPAGE - 1);

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     win_idx;
    logic [NREQ-1:0]   win_oh;
    logic [PW-1:0]     pick_idx;
    logic [NREQ-1:0]   pick_oh;
    logic              pick_valid;
    logic [DW-1:0]     shadow;
    logic [PAGEW-1:0]  page;
    logic [DCW-1:0]    dwell;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req    (req),
        .rrPtr  (rr_ptr),
        .winner (pick_oh),
        .winIdx (pick_idx),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            // NOTE: the shadow word is cleared as well, so a stale word can never reappear on the bank.
            shadow  <= '0;
            page    <= '0;
            dwell   <= '0;
            win_idx <= '0;
            win_oh  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        win_idx <= pick_idx;
                        win_oh  <= pick_oh;
                    end
                end
                GRANT: begin
                    shadow <= reqData[win_idx*DW +: DW];
                    rr_ptr <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
                    page   <= '0;
                    dwell  <= '0;
                end
                SHOW: begin
                    if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        page  <= page + 1'b1;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        gnt        = '0;
        busy       = 1'b0;
        ledOut     = '0;
        done       = 1'b0;
`ifdef LED_PAGE_IDX_EN
        pageIdx    = '0;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) state_next = GRANT;
            end
            GRANT: begin
                gnt        = win_oh;
                busy       = 1'b1;
                state_next = SHOW;
            end
            SHOW: begin
                busy   = 1'b1;
                ledOut = page_slice(shadow, page);
`ifdef LED_PAGE_IDX_EN
                pageIdx = page;
`endif
                if (page == PAGE_LAST && dwell == DWELL_LAST) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_page_scheduler.sv
// Self-checking bench for led_page_scheduler (NREQ=4, DWELL=4) with a transfer-offset model.
`timescale 1ns/1ps
module tb_led_page_scheduler;

    localparam int NREQ     = 4;
    localparam int DW       = 32;
    localparam int LEDW     = 10;
    localparam int DWELL    = 4;
    localparam int NPAGE    = 4;
    localparam int SHOW_LEN = NPAGE * DWELL;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*DW-1:0] reqData = '0;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [LEDW-1:0]   ledOut;
    logic              done;
`ifdef LED_PAGE_IDX_EN
    logic [1:0]        pageIdx;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [LEDW-1:0] s1_pages [4] = '{10'h001, 10'h3FF, 10'h000, 10'h003};
    int              s2_order [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    led_page_scheduler #(.NREQ(NREQ), .DW(DW), .LEDW(LEDW), .DWELL(DWELL)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .reqData (reqData),
        .gnt     (gnt),
        .busy    (busy),
        .ledOut  (ledOut),
        .done    (done)
`ifdef LED_PAGE_IDX_EN
        ,
        .pageIdx (pageIdx)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a transfer is a run of offsets from the grant cycle:
    // 0 = grant, 1..SHOW_LEN = page (off-1)/DWELL, SHOW_LEN+1 = done, then idle.
    bit              m_active = 1'b0;
    bit              cmp_en   = 1'b0;
    int              m_off    = 0;
    int              m_win    = 0;
    int              m_rr     = 0;
    logic [DW-1:0]   m_word   = '0;

    always @(posedge clk) begin
        cyc++;
        if (!resetn) begin
            m_active = 1'b0;
            m_off    = 0;
            m_rr     = 0;
            m_word   = '0;
            cmp_en   = 1'b1;
        end else if (m_active) begin
            if (m_off == 0) begin
                m_word = reqData[m_win*DW +: DW];
                m_rr   = (m_win + 1) % NREQ;
            end
            m_off++;
            if (m_off == SHOW_LEN + 2) m_active = 1'b0;
        end else if (req != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[(m_rr + i) % NREQ]) begin
                    m_win = (m_rr + i) % NREQ;
                    break;
                end
            end
            m_active = 1'b1;
            m_off    = 0;
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] e_gnt;
        logic            e_busy;
        logic            e_done;
        logic [LEDW-1:0] e_led;
        int              e_page;
        if (cmp_en) begin
            e_gnt  = '0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_led  = '0;
            e_page = 0;
            if (m_active) begin
                e_busy = 1'b1;
                if (m_off == 0) begin
                    e_gnt[m_win] = 1'b1;
                end else if (m_off <= SHOW_LEN) begin
                    e_page = (m_off - 1) / DWELL;
                    e_led  = LEDW'(m_word >> (e_page * LEDW));
                end else begin
                    e_done = 1'b1;
                end
            end
            check("gnt", gnt, e_gnt);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("ledOut", ledOut, e_led);
`ifdef LED_PAGE_IDX_EN
            check("pageIdx", pageIdx, e_page);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Returns at the negedge of the grant cycle (or after the budget, flagged as a failure).
    task automatic wait_grant(input string name, input logic [NREQ-1:0] want, output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 100);
        check(name, gnt, want);
        at = cyc;
    endtask

    task automatic wait_done(input string name, output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 100);
        check(name, done, 1'b1);
        at = cyc;
    endtask

    initial begin
        int g_at;
        int d_at;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_gnt", gnt, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_led", ledOut, '0);
        check("rst_done", done, 1'b0);
        tick();
        resetn = 1'b1;

        // 1: single request, literal page values
        tick();
        reqData[0 +: DW] = 32'hC00F_FC01;
        req = 4'b0001;
        tick();
        @(negedge clk);
        check("s1_gnt", gnt, 4'b0001);
        req = '0;
        for (int k = 0; k < NPAGE; k++) begin
            for (int d = 0; d < DWELL; d++) begin
                tick();
                @(negedge clk);
                check($sformatf("s1_page%0d_%0d", k, d), ledOut, s1_pages[k]);
`ifdef LED_PAGE_IDX_EN
                check($sformatf("s1_idx%0d_%0d", k, d), pageIdx, k);
`endif
            end
        end
        tick();
        @(negedge clk);
        check("s1_done", done, 1'b1);
        check("s1_done_led", ledOut, '0);
        tick();
        @(negedge clk);
        check("s1_idle_busy", busy, 1'b0);
        check("s1_idle_led", ledOut, '0);

        // 3: word changes during SHOW; latched word keeps showing (rrPtr=1, requester 0 still wins)
        reqData[0 +: DW] = 32'h1234_5678;
        req = 4'b0001;
        wait_grant("s3_gnt", 4'b0001, g_at);
        req = '0;
        repeat (5) tick();
        reqData[0 +: DW] = 32'hFFFF_FFFF;
        repeat (5) tick();
        @(negedge clk);
        check("s3_page2", ledOut, 10'h123);
        repeat (4) tick();
        @(negedge clk);
        check("s3_page3", ledOut, 10'h000);
        wait_done("s3_done", d_at);

        // 4: reset on page 2 abandons the transfer and returns rrPtr to 0
        req = 4'b0100;
        wait_grant("s4_gnt", 4'b0100, g_at);
        req = '0;
        repeat (9) tick();
        resetn = 1'b0;
        tick();
        @(negedge clk);
        check("s4_rst_led", ledOut, '0);
        check("s4_rst_busy", busy, 1'b0);
        check("s4_rst_gnt", gnt, '0);
        check("s4_rst_done", done, 1'b0);
        resetn = 1'b1;
        req = 4'b0101;
        wait_grant("s4_rr0", 4'b0001, g_at);
        req = '0;
        wait_done("s4_done", d_at);

        // 5: move rrPtr to 2, then req=1010 grants 3 before 1
        req = 4'b0010;
        wait_grant("s5_setup", 4'b0010, g_at);
        tick();
        req = 4'b1010;
        wait_grant("s5_first", 4'b1000, g_at);
        wait_grant("s5_second", 4'b0010, g_at);
        req = '0;
        wait_done("s5_done", d_at);

        // 2: full contention from a fresh reset
        tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant($sformatf("s2_gnt%0d", i), NREQ'(1) << s2_order[i], g_at);
            if (i == 4) req = '0;
            wait_done($sformatf("s2_done%0d", i), d_at);
            check($sformatf("s2_len%0d", i), d_at - g_at, 1 + SHOW_LEN);
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
